// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DZ   = 2'd2
  } state_e;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   op         0 = multiply step, 1 = divide step
//   acc_hi/lo  current accumulator pair
//   m          multiplicand / divisor
//   acc_*_nxt  accumulator pair after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_hi_nxt,
  output logic [WIDTH-1:0] acc_lo_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    r   = {acc_hi, acc_lo[WIDTH-1]};
    ge  = (r >= {1'b0, m});
    // The partial remainder is always below 2*m, so r - m fits in WIDTH
    // bits whenever it is taken; the dropped top bit is known to be zero.
    diff = r[WIDTH-1:0] - m;

    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;
    if (op == OP_MULTU) begin
      acc_hi_nxt = sum[WIDTH:1];
      acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    end else if (ge) begin
      acc_hi_nxt = diff;
      acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      acc_hi_nxt = r[WIDTH-1:0];
      acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multu/divu unit owning the architectural HI/LO pair.
// Latency: WIDTH busy cycles per operation (1 for divide-by-zero), done pulses the cycle after.
// Backpressure: stall = busy & (start | rd_req); a start while busy waits until IDLE.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op         issue request (level) and opcode (0 multu, 1 divu)
//   rs_val, rt_val    operands from the register file
//   rd_req            current instruction reads HI/LO
//   busy, stall       operation in flight / freeze PC and gate write-back
//   done, dz          result-written pulse / last divide had zero divisor
//   hi, lo            architectural HI and LO
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             op_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, m_q;
  logic [WIDTH-1:0] acc_hi_nxt, acc_lo_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dz_q, done_q;

  logic             accept;
  logic             finish_run;
  logic             finish_dz;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op         (op_q),
    .acc_hi     (acc_hi_q),
    .acc_lo     (acc_lo_q),
    .m          (m_q),
    .acc_hi_nxt (acc_hi_nxt),
    .acc_lo_nxt (acc_lo_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    finish_run = 1'b0;
    finish_dz  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (op == OP_DIVU && rt_val == '0) ? DZ : RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          finish_run = 1'b1;
          state_d    = IDLE;
        end
      end
      DZ: begin
        finish_dz = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_MULTU;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish_run | finish_dz;

      // acc_lo also keeps rs for the divide-by-zero path, which writes it to HI.
      if (accept) begin
        op_q     <= op;
        acc_hi_q <= '0;
        acc_lo_q <= rs_val;
        m_q      <= rt_val;
        cnt_q    <= '0;
        dz_q     <= 1'b0;
      end else if (state_q == RUN) begin
        acc_hi_q <= acc_hi_nxt;
        acc_lo_q <= acc_lo_nxt;
        cnt_q    <= cnt_q + CNT_W'(1);
      end

      // HI/LO are only touched at completion so mfhi/mflo see stable values.
      if (finish_run) begin
        hi_q <= acc_hi_nxt;
        lo_q <= acc_lo_nxt;
        dz_q <= 1'b0;
      end
      if (finish_dz) begin
        hi_q <= acc_lo_q;
        lo_q <= '1;
        dz_q <= 1'b1;
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = busy & (start | rd_req);
  assign done  = done_q;
  assign dz    = dz_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
